// File: rtl/mmio_interconnect_pkg.sv
// rtl/mmio_interconnect_pkg.sv - shared types and constants for the MMIO interconnect
package mmio_interconnect_pkg;

  // Access size field is MEMORY_ACCESS_SIZE+1 bits wide so it can encode 4.
  localparam int MEMORY_ACCESS_SIZE = 2;
  localparam int SIZE_W             = MEMORY_ACCESS_SIZE + 1;

  // RAM window size used by the default address map.
  localparam logic [31:0] MEMORY_SIZE = 32'h0100_0000;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = SIZE_W'(1);
  localparam logic [SIZE_W-1:0] SIZE_HALF = SIZE_W'(2);
  localparam logic [SIZE_W-1:0] SIZE_WORD = SIZE_W'(4);

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_SLAVE    = 3'd1;
  localparam logic [2:0] ERR_UNMAPPED = 3'd2;
  localparam logic [2:0] ERR_ALIGN    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/mmio_addr_decoder.sv
// rtl/mmio_addr_decoder.sv - combinational slave select, offset and size/alignment check
module mmio_addr_decoder
  import mmio_interconnect_pkg::*;
#(
  parameter int                   NUM_RX      = 4,
  parameter int                   IDX_W       = 2,
  parameter bit                   CHECK_ALIGN = 1'b1,
  parameter logic [NUM_RX*32-1:0] RX_BASE     = '0,
  parameter logic [NUM_RX*32-1:0] RX_LIMIT    = '0
) (
  input  logic [31:0]       addr,
  input  logic [SIZE_W-1:0] size,
  output logic              hit,
  output logic [IDX_W-1:0]  index,
  output logic [31:0]       offset,
  output logic              align_ok
);

  logic [31:0] base;

  // Scan from the top index down so the lowest matching slave wins on overlap.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    base  = RX_BASE[31:0];
    for (int k = NUM_RX - 1; k >= 0; k--) begin
      if (addr >= RX_BASE[k*32 +: 32] && addr <= RX_LIMIT[k*32 +: 32]) begin
        hit   = 1'b1;
        index = IDX_W'(k);
        base  = RX_BASE[k*32 +: 32];
      end
    end
    offset = addr - base;
  end

  // Only 1/2/4-byte accesses are legal; natural alignment is optional.
  always_comb begin
    align_ok = 1'b0;
    case (size)
      SIZE_BYTE: align_ok = 1'b1;
      SIZE_HALF: align_ok = !CHECK_ALIGN || (addr[0] == 1'b0);
      SIZE_WORD: align_ok = !CHECK_ALIGN || (addr[1:0] == 2'b00);
      default:   align_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/mmio_interconnect.sv
// rtl/mmio_interconnect.sv - single-master N-slave MMIO router with error causes and timeout
module mmio_interconnect
  import mmio_interconnect_pkg::*;
#(
  parameter int                   NUM_RX         = 4,
  parameter logic [NUM_RX*32-1:0] RX_BASE        = {32'h8000_0000, 32'h0201_0000,
                                                    32'h1001_3000, 32'h0200_0000},
  parameter logic [NUM_RX*32-1:0] RX_LIMIT       = {32'h8000_0000 + MEMORY_SIZE - 32'd1,
                                                    32'h0201_03FF, 32'h1001_3FFF,
                                                    32'h0200_FFFF},
  parameter int                   TIMEOUT_CYCLES = 64,
  parameter bit                   CHECK_ALIGN    = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          tx_mem_addr,
  input  logic [SIZE_W-1:0]    tx_mem_size,
  input  logic                 tx_mem_enable,
  input  logic                 tx_mem_w_mode,
  input  logic [31:0]          tx_mem_w_data,
  output logic [31:0]          tx_mem_r_data,
  output logic                 tx_mem_ready,
  output logic                 tx_mem_done,
  output logic                 tx_mem_error,
  output logic [2:0]           tx_mem_err_cause,
  output logic [31:0]          rx_mem_addr,
  output logic [SIZE_W-1:0]    rx_mem_size,
  output logic                 rx_mem_w_mode,
  output logic [31:0]          rx_mem_w_data,
  output logic [NUM_RX-1:0]    rx_mem_enable,
  input  logic [NUM_RX*32-1:0] rx_mem_r_data,
  input  logic [NUM_RX-1:0]    rx_mem_done,
  input  logic [NUM_RX-1:0]    rx_mem_error
);

  localparam int IDX_W = (NUM_RX > 1) ? $clog2(NUM_RX) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The counter reads 0 in the first WAIT cycle, so the last allowed sample is T-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sel_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic [31:0]        dec_offset;
  logic               dec_align_ok;

  logic               sel_resp;
  logic               sel_err;
  logic [31:0]        sel_rdata;
  logic               timeout_hit;

  mmio_addr_decoder #(
    .NUM_RX      (NUM_RX),
    .IDX_W       (IDX_W),
    .CHECK_ALIGN (CHECK_ALIGN),
    .RX_BASE     (RX_BASE),
    .RX_LIMIT    (RX_LIMIT)
  ) u_decoder (
    .addr     (tx_mem_addr),
    .size     (tx_mem_size),
    .hit      (dec_hit),
    .index    (dec_idx),
    .offset   (dec_offset),
    .align_ok (dec_align_ok)
  );

  assign tx_mem_ready = (state_q == ST_IDLE) && !tx_mem_enable;

  // Response mux: only the slave latched at accept is ever observed.
  always_comb begin
    sel_resp    = rx_mem_done[sel_q] | rx_mem_error[sel_q];
    sel_err     = rx_mem_error[sel_q];
    sel_rdata   = rx_mem_r_data[32*sel_q +: 32];
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
  end

  // Next state: decode errors stay in IDLE; ISSUE is always exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (tx_mem_enable && dec_align_ok && dec_hit) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (sel_resp || timeout_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath: request capture, strobe, completion status and timeout counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q            <= '0;
      cnt_q            <= '0;
      rx_mem_enable    <= '0;
      rx_mem_addr      <= '0;
      rx_mem_size      <= '0;
      rx_mem_w_mode    <= 1'b0;
      rx_mem_w_data    <= '0;
      tx_mem_done      <= 1'b0;
      tx_mem_error     <= 1'b0;
      tx_mem_err_cause <= ERR_NONE;
      tx_mem_r_data    <= '0;
    end else begin
      tx_mem_done   <= 1'b0;
      rx_mem_enable <= '0;
      case (state_q)
        ST_IDLE: begin
          if (tx_mem_enable) begin
            rx_mem_addr      <= dec_offset;
            rx_mem_size      <= tx_mem_size;
            rx_mem_w_mode    <= tx_mem_w_mode;
            rx_mem_w_data    <= tx_mem_w_data;
            tx_mem_error     <= 1'b0;
            tx_mem_err_cause <= ERR_NONE;
            if (!dec_align_ok) begin
              tx_mem_done      <= 1'b1;
              tx_mem_error     <= 1'b1;
              tx_mem_err_cause <= ERR_ALIGN;
            end else if (!dec_hit) begin
              tx_mem_done      <= 1'b1;
              tx_mem_error     <= 1'b1;
              tx_mem_err_cause <= ERR_UNMAPPED;
            end else begin
              rx_mem_enable <= NUM_RX'(1) << dec_idx;
              sel_q         <= dec_idx;
            end
          end
        end
        ST_ISSUE: cnt_q <= '0;
        ST_WAIT: begin
          if (sel_resp) begin
            tx_mem_done      <= 1'b1;
            tx_mem_error     <= sel_err;
            tx_mem_err_cause <= sel_err ? ERR_SLAVE : ERR_NONE;
            if (!rx_mem_w_mode) tx_mem_r_data <= sel_rdata;
          end else if (timeout_hit) begin
            tx_mem_done      <= 1'b1;
            tx_mem_error     <= 1'b1;
            tx_mem_err_cause <= ERR_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_interconnect.sv
// tb/tb_mmio_interconnect.sv - scoreboard bench for mmio_interconnect
module tb_mmio_interconnect;
  import mmio_interconnect_pkg::*;

  localparam int NRX = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       tx_mem_addr = '0;
  logic [SIZE_W-1:0] tx_mem_size = '0;
  logic              tx_mem_enable = 1'b0;
  logic              tx_mem_w_mode = 1'b0;
  logic [31:0]       tx_mem_w_data = '0;
  logic [31:0]       tx_mem_r_data;
  logic              tx_mem_ready;
  logic              tx_mem_done;
  logic              tx_mem_error;
  logic [2:0]        tx_mem_err_cause;
  logic [31:0]       rx_mem_addr;
  logic [SIZE_W-1:0] rx_mem_size;
  logic              rx_mem_w_mode;
  logic [31:0]       rx_mem_w_data;
  logic [NRX-1:0]    rx_mem_enable;
  logic [NRX*32-1:0] rx_mem_r_data = '0;
  logic [NRX-1:0]    rx_mem_done = '0;
  logic [NRX-1:0]    rx_mem_error = '0;

  mmio_interconnect dut (
    .clock            (clock),
    .reset            (reset),
    .tx_mem_addr      (tx_mem_addr),
    .tx_mem_size      (tx_mem_size),
    .tx_mem_enable    (tx_mem_enable),
    .tx_mem_w_mode    (tx_mem_w_mode),
    .tx_mem_w_data    (tx_mem_w_data),
    .tx_mem_r_data    (tx_mem_r_data),
    .tx_mem_ready     (tx_mem_ready),
    .tx_mem_done      (tx_mem_done),
    .tx_mem_error     (tx_mem_error),
    .tx_mem_err_cause (tx_mem_err_cause),
    .rx_mem_addr      (rx_mem_addr),
    .rx_mem_size      (rx_mem_size),
    .rx_mem_w_mode    (rx_mem_w_mode),
    .rx_mem_w_data    (rx_mem_w_data),
    .rx_mem_enable    (rx_mem_enable),
    .rx_mem_r_data    (rx_mem_r_data),
    .rx_mem_done      (rx_mem_done),
    .rx_mem_error     (rx_mem_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          edge_n;
    logic [31:0] rdata;
    logic        err;
    logic [2:0]  cause;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model_rd = '0;
  int          ecount = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clock) ecount <= ecount + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest expected result.
  always @(negedge clock) begin
    if (tx_mem_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", ecount, mon_e.edge_n);
        chk("r_data", tx_mem_r_data, mon_e.rdata);
        chk("error", {31'd0, tx_mem_error}, {31'd0, mon_e.err});
        chk("cause", {29'd0, tx_mem_err_cause}, {29'd0, mon_e.cause});
      end
    end
  end

  // One access: cycle k is the cycle after accept edge + k-1; the slave model
  // drives done/error for the selected index in cycle resp_at (or always if hold).
  task automatic access(input string tag, input logic [31:0] addr, input logic [2:0] size,
                        input logic w, input logic [31:0] wd, input int sel,
                        input logic [31:0] off, input int resp_at, input logic resp_err,
                        input logic hold, input logic [31:0] rd, input int done_cyc,
                        input logic [2:0] cause, input int run_cyc);
    int   acc;
    exp_t e;
    @(posedge clock); #1;
    chk({tag, ":ready"}, {31'd0, tx_mem_ready}, 32'd1);
    tx_mem_addr   = addr;
    tx_mem_size   = size;
    tx_mem_w_mode = w;
    tx_mem_w_data = wd;
    tx_mem_enable = 1'b1;
    acc = ecount + 1;
    if (!w && sel >= 0 && (cause == ERR_NONE || cause == ERR_SLAVE)) model_rd = rd;
    e.edge_n = acc + done_cyc - 1;
    e.rdata  = model_rd;
    e.err    = (cause != ERR_NONE);
    e.cause  = cause;
    sb.push_back(e);
    for (int j = 0; j < NRX; j++) rx_mem_r_data[j*32 +: 32] = (j == sel) ? rd : ~rd;
    for (int k = 1; k <= run_cyc; k++) begin
      @(posedge clock); #1;
      tx_mem_enable = 1'b0;
      if (k == 1) begin
        chk({tag, ":strobe"}, {28'd0, rx_mem_enable}, (sel >= 0) ? (32'd1 << sel) : 32'd0);
        if (sel >= 0) chk({tag, ":offset"}, rx_mem_addr, off);
        if (w) chk({tag, ":w_data"}, rx_mem_w_data, wd);
      end
      if (k == 2) chk({tag, ":strobe_off"}, {28'd0, rx_mem_enable}, 32'd0);
      rx_mem_done  = '0;
      rx_mem_error = '0;
      if (sel >= 0) begin
        rx_mem_done[sel]  = hold || (k == resp_at);
        rx_mem_error[sel] = resp_err && (k == resp_at);
      end
    end
    rx_mem_done  = '0;
    rx_mem_error = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=%0d exp=finish", ecount);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_done", {31'd0, tx_mem_done}, 32'd0);
    chk("rst_error", {31'd0, tx_mem_error}, 32'd0);
    chk("rst_cause", {29'd0, tx_mem_err_cause}, 32'd0);
    chk("rst_rdata", tx_mem_r_data, 32'd0);
    chk("rst_rx_addr", rx_mem_addr, 32'd0);
    chk("rst_strobe", {28'd0, rx_mem_enable}, 32'd0);
    reset = 1'b0;

    access("rd_ram",   32'h8000_0010, 3'd4, 1'b0, 32'd0,  3, 32'h10, 2, 1'b0, 1'b0, 32'hDEAD_BEEF, 3, ERR_NONE, 4);
    access("wr_clint", 32'h0201_0000, 3'd4, 1'b1, 32'd93, 2, 32'h0,  2, 1'b0, 1'b0, 32'h5555_AAAA, 3, ERR_NONE, 4);
    access("unmapped", 32'h4000_0000, 3'd4, 1'b0, 32'd0, -1, 32'h0,  0, 1'b0, 1'b0, 32'h0, 1, ERR_UNMAPPED, 2);
    access("mis_word", 32'h8000_0002, 3'd4, 1'b0, 32'd0, -1, 32'h0,  0, 1'b0, 1'b0, 32'h0, 1, ERR_ALIGN, 2);
    access("bad_size", 32'h8000_0000, 3'd3, 1'b0, 32'd0, -1, 32'h0,  0, 1'b0, 1'b0, 32'h0, 1, ERR_ALIGN, 2);
    access("mis_half", 32'h8000_0001, 3'd2, 1'b0, 32'd0, -1, 32'h0,  0, 1'b0, 1'b0, 32'h0, 1, ERR_ALIGN, 2);
    access("rd_half",  32'h8000_0002, 3'd2, 1'b0, 32'd0,  3, 32'h2,  2, 1'b0, 1'b0, 32'h0000_BEEF, 3, ERR_NONE, 4);
    access("rd_uart",  32'h1001_3003, 3'd1, 1'b0, 32'd0,  1, 32'h3,  5, 1'b0, 1'b0, 32'h0000_0042, 6, ERR_NONE, 7);
    access("timeout",  32'h1001_3000, 3'd4, 1'b0, 32'd0,  1, 32'h0, 70, 1'b0, 1'b0, 32'h1111_1111, 66, ERR_TIMEOUT, 72);
    access("post_to",  32'h0200_0004, 3'd4, 1'b0, 32'd0,  0, 32'h4,  4, 1'b0, 1'b0, 32'h1234_5678, 5, ERR_NONE, 6);
    access("hold",     32'h8000_0100, 3'd4, 1'b0, 32'd0,  3, 32'h100, 0, 1'b0, 1'b1, 32'hCAFE_F00D, 3, ERR_NONE, 4);
    access("slv_err",  32'h8000_0200, 3'd4, 1'b0, 32'd0,  3, 32'h200, 2, 1'b1, 1'b0, 32'hBADB_AD00, 3, ERR_SLAVE, 4);

    // Reset in the ISSUE cycle drops the strobe and the access entirely.
    @(posedge clock); #1;
    tx_mem_addr   = 32'h8000_0020;
    tx_mem_size   = 3'd4;
    tx_mem_w_mode = 1'b0;
    tx_mem_enable = 1'b1;
    @(posedge clock); #1;
    tx_mem_enable = 1'b0;
    chk("rst_issue:strobe", {28'd0, rx_mem_enable}, 32'd8);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_issue:strobe_drop", {28'd0, rx_mem_enable}, 32'd0);
    chk("rst_issue:done", {31'd0, tx_mem_done}, 32'd0);
    chk("rst_issue:error", {31'd0, tx_mem_error}, 32'd0);
    chk("rst_issue:rdata", tx_mem_r_data, 32'd0);
    chk("rst_issue:rx_addr", rx_mem_addr, 32'd0);
    chk("rst_issue:ready", {31'd0, tx_mem_ready}, 32'd1);
    model_rd = '0;
    reset = 1'b0;

    access("after_rst", 32'h8000_0040, 3'd4, 1'b0, 32'd0, 3, 32'h40, 3, 1'b0, 1'b0, 32'h0BAD_CAFE, 4, ERR_NONE, 5);

    repeat (3) @(posedge clock);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
